// File: rtl/mag_sq_feeder_pkg.sv
// mag_sq_feeder_pkg
// Shared constants, FSM state encoding and helpers for the magnitude feeder
// and its shift-add squarer.
package mag_sq_feeder_pkg;

  localparam int unsigned W_IN    = 8;   // signed dx/dy width (only 8 supported)
  localparam int unsigned W_SQ    = 16;  // sum-of-squares / sqrt operand width
  localparam int unsigned MAG_MAX = 181; // floor(sqrt(2 * 128^2))
  localparam int unsigned W_MAG   = $clog2(MAG_MAX + 1);
  localparam int unsigned W_CNT   = 3;   // 8 shift-add iterations per square

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQX,
    ST_SQY,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_e;

  // Two's-complement magnitude as unsigned; -128 maps to 128.
  function automatic logic [W_IN-1:0] abs_in(input logic [W_IN-1:0] v);
    return v[W_IN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mag_sq_feeder_if.sv
// mag_sq_feeder_if
// Bundles the three handshakes of the feeder:
//   input channel  : in_valid/in_ready, dx, dy
//   sqrt channel   : sq_num, sq_ready (start pulse), sq_done, sq_res
//   output channel : out_valid/out_ready, mag, sumsq
// master = the feeder itself, slave = its surroundings (upstream, sqrt stage,
// downstream).
interface mag_sq_feeder_if;
  import mag_sq_feeder_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [W_IN-1:0] dx;
  logic signed [W_IN-1:0] dy;
  logic [W_SQ-1:0]        sq_num;
  logic                   sq_ready;
  logic                   sq_done;
  logic [W_SQ-1:0]        sq_res;
  logic                   out_valid;
  logic                   out_ready;
  logic [W_MAG-1:0]       mag;
  logic [W_SQ-1:0]        sumsq;

  modport master (
    input  in_valid, dx, dy, sq_done, sq_res, out_ready,
    output in_ready, sq_num, sq_ready, out_valid, mag, sumsq
  );

  modport slave (
    output in_valid, dx, dy, sq_done, sq_res, out_ready,
    input  in_ready, sq_num, sq_ready, out_valid, mag, sumsq
  );

endinterface

// File: rtl/mag_sq_feeder_seq_squarer.sv
// mag_sq_feeder_seq_squarer
// 8-iteration shift-add unsigned squarer: sum = seed + operand^2.
// The start cycle performs iteration 0 directly from operand/seed, the next
// seven busy cycles perform iterations 1..7, so the result is in sum after
// the 8th clock edge counted from (and including) the start cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load operand/seed and perform the first iteration
//   operand    : 8-bit unsigned value to square
//   seed       : 16-bit value the square is accumulated onto
//   sum        : accumulator (registered), held once busy drops
//   busy       : iterations 1..7 in progress
module mag_sq_feeder_seq_squarer
  import mag_sq_feeder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W_IN-1:0] operand,
  input  logic [W_SQ-1:0] seed,
  output logic [W_SQ-1:0] sum,
  output logic            busy
);

  logic [W_SQ-1:0]  acc_q, acc_d;
  logic [W_SQ-1:0]  mcand_q, mcand_d;
  logic [W_IN-1:0]  mplier_q, mplier_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [W_SQ-1:0]  op_ext;

  assign op_ext = W_SQ'(operand);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = seed + (operand[0] ? op_ext : '0);
      mcand_d  = op_ext << 1;
      mplier_d = operand >> 1;
      cnt_d    = W_CNT'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign sum  = acc_q;
  assign busy = busy_q;

endmodule

// File: rtl/mag_sq_feeder.sv
// mag_sq_feeder
// Front-end for the 16-bit iterative square-root stage: accepts a signed
// (dx, dy), forms dx^2+dy^2 with one shared shift-add squarer (8 cycles per
// component), issues the sum to the sqrt stage with a one-cycle start pulse,
// captures the root and presents mag = floor(sqrt(dx^2+dy^2)) and sumsq.
// Accept-to-start is 17 cycles; one vector in flight at a time.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mag_sq_feeder_if master (input, sqrt and output channels)
module mag_sq_feeder
  import mag_sq_feeder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mag_sq_feeder_if.master bus
);

  state_e           state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_IN-1:0]  ax_q, ax_d;
  logic [W_IN-1:0]  ay_q, ay_d;
  logic [W_SQ-1:0]  sq_num_q, sq_num_d;
  logic [W_SQ-1:0]  sumsq_q, sumsq_d;
  logic [W_MAG-1:0] mag_q, mag_d;

  logic             sqr_start;
  logic [W_IN-1:0]  sqr_op;
  logic [W_SQ-1:0]  sqr_seed;
  logic [W_SQ-1:0]  sqr_sum;
  logic             sqr_busy;

  logic             in_ready;
  logic             sq_ready;
  logic             out_valid;

  // Legal operands never produce a root above 181, so the upper half is 0.
  logic             unused_res_hi;
  assign unused_res_hi = ^bus.sq_res[W_SQ-1:W_MAG];

  mag_sq_feeder_seq_squarer u_seq_squarer (
    .clk     (clk),
    .reset   (reset),
    .start   (sqr_start),
    .operand (sqr_op),
    .seed    (sqr_seed),
    .sum     (sqr_sum),
    .busy    (sqr_busy)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    sq_num_d  = sq_num_q;
    sumsq_d   = sumsq_q;
    mag_d     = mag_q;
    sqr_start = 1'b0;
    sqr_op    = ax_q;
    sqr_seed  = '0;
    in_ready  = 1'b0;
    sq_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ax_d    = abs_in(bus.dx);
          ay_d    = abs_in(bus.dy);
          cnt_d   = '0;
          state_d = ST_SQX;
        end
      end
      ST_SQX: begin
        // Zero seed clears the accumulator for the new vector.
        sqr_op    = ax_q;
        sqr_seed  = '0;
        sqr_start = (cnt_q == '0) && !sqr_busy;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_SQY;
        end
      end
      ST_SQY: begin
        // Seeding with the registered dx^2 accumulates dy^2 on top of it.
        sqr_op    = ay_q;
        sqr_seed  = sqr_sum;
        sqr_start = (cnt_q == '0) && !sqr_busy;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        sq_ready = 1'b1;
        sq_num_d = sqr_sum;
        sumsq_d  = sqr_sum;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sq_done) begin
          mag_d   = bus.sq_res[W_MAG-1:0];
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      sq_num_q <= '0;
      sumsq_q  <= '0;
      mag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      sq_num_q <= sq_num_d;
      sumsq_q  <= sumsq_d;
      mag_q    <= mag_d;
    end
  end

  // The final sum lands in the squarer on the edge that enters REQ, so during
  // the start pulse the operand is taken straight from the squarer; the
  // register holds the identical value from WAIT onwards, keeping sq_num
  // continuous across the whole start-to-done window.
  assign bus.sq_num    = (state_q == ST_REQ) ? sqr_sum : sq_num_q;
  assign bus.sumsq     = sumsq_q;
  assign bus.mag       = mag_q;
  assign bus.in_ready  = in_ready;
  assign bus.sq_ready  = sq_ready;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_mag_sq_feeder.sv
// tb_mag_sq_feeder
// Directed bench for mag_sq_feeder with a behavioural square-root responder
// (configurable latency, reads its operand live, shares the reset).
module tb_mag_sq_feeder;
  import mag_sq_feeder_pkg::*;

  logic clk;
  logic reset;

  mag_sq_feeder_if bus ();

  mag_sq_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder / protocol monitor state
  int              sqrt_lat     = 5;
  int              ready_pulses = 0;
  bit              double_ready = 1'b0;
  bit              num_changed  = 1'b0;
  bit              rsp_busy     = 1'b0;
  bit              prev_ready   = 1'b0;
  int              rsp_left     = 0;
  logic [W_SQ-1:0] held_num     = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  // Square-root stage model
  initial begin
    bus.sq_done = 1'b0;
    bus.sq_res  = '0;
    forever begin
      tick();
      bus.sq_done = 1'b0;
      if (reset) begin
        rsp_busy   = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (prev_ready && bus.sq_ready) double_ready = 1'b1;
        prev_ready = bus.sq_ready;
        if (rsp_busy && bus.sq_num !== held_num) num_changed = 1'b1;
        if (bus.sq_ready) begin
          rsp_busy = 1'b1;
          rsp_left = sqrt_lat;
          held_num = bus.sq_num;
          ready_pulses++;
        end else if (rsp_busy) begin
          rsp_left--;
          if (rsp_left == 0) begin
            bus.sq_done = 1'b1;
            bus.sq_res  = W_SQ'(isqrt(int'(bus.sq_num)));
            rsp_busy    = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_in_ready(input string tag);
    int c;
    c = 0;
    while (!bus.in_ready && c < 300) begin
      tick();
      c++;
    end
    if (!bus.in_ready) check({tag, "_in_ready_timeout"}, bus.in_ready, 1);
  endtask

  // Presents a vector and returns one cycle after the accepting edge.
  task automatic send(input logic signed [7:0] x, input logic signed [7:0] y, input string tag);
    bus.dx = x;
    bus.dy = y;
    bus.in_valid = 1'b1;
    wait_in_ready(tag);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    c = 1;
    while (!bus.sq_ready && c < 300) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_out(input string tag);
    int c;
    c = 0;
    while (!bus.out_valid && c < 300) begin
      tick();
      c++;
    end
    check({tag, "_out_valid"}, bus.out_valid, 1);
  endtask

  task automatic run_vec(input logic signed [7:0] x, input logic signed [7:0] y,
                         input int exp_mag, input int exp_sum, input string tag);
    send(x, y, tag);
    wait_out(tag);
    check({tag, "_mag"}, bus.mag, exp_mag);
    check({tag, "_sumsq"}, bus.sumsq, exp_sum);
    tick();
  endtask

  initial begin
    int c;
    int p0;
    int xi, yi, es;
    logic signed [7:0] x, y;

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dx        = '0;
    bus.dy        = '0;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_sq_ready",  bus.sq_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sq_num",    bus.sq_num,    0);
    check("rst_mag",       bus.mag,       0);
    check("rst_sumsq",     bus.sumsq,     0);
    reset = 1'b0;
    tick();

    // 1: 3,4 -> start 17 cycles after accept, operand 25, mag 5
    p0 = ready_pulses;
    send(8'sd3, 8'sd4, "t1");
    check("t1_in_ready_busy", bus.in_ready, 0);
    wait_ready(c);
    check("t1_latency", c, 17);
    check("t1_sq_num", bus.sq_num, 25);
    tick();
    check("t1_sq_ready_drop", bus.sq_ready, 0);
    check("t1_sq_num_held", bus.sq_num, 25);
    wait_out("t1");
    check("t1_mag", bus.mag, 5);
    check("t1_sumsq", bus.sumsq, 25);
    check("t1_pulses", ready_pulses - p0, 1);
    tick();

    // 2, 3: boundary vectors
    sqrt_lat = 1;
    run_vec(-8'sd128, -8'sd128, 181, 32768, "t2");
    sqrt_lat = 7;
    run_vec(8'sd0, 8'sd0, 0, 0, "t3a");
    run_vec(-8'sd1, 8'sd0, 1, 1, "t3b");
    run_vec(8'sd7, -8'sd7, 9, 98, "t3c");

    // 4: back-pressure on the output channel
    sqrt_lat = 4;
    bus.out_ready = 1'b0;
    send(8'sd5, 8'sd12, "t4");
    wait_out("t4");
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", bus.out_valid, 1);
      check("t4_hold_mag", bus.mag, 13);
      check("t4_hold_sumsq", bus.sumsq, 169);
      check("t4_hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("t4_release_in_ready", bus.in_ready, 1);
    check("t4_release_out_valid", bus.out_valid, 0);

    // 5: reset while waiting on the sqrt stage (operand 1000)
    sqrt_lat = 20;
    send(8'sd30, 8'sd10, "t5");
    wait_ready(c);
    check("t5_sq_num", bus.sq_num, 1000);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_in_ready", bus.in_ready, 1);
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_sq_ready", bus.sq_ready, 0);
    check("t5_sumsq", bus.sumsq, 0);
    for (int i = 0; i < 25; i++) tick();
    check("t5_no_stale_valid", bus.out_valid, 0);
    check("t5_no_stale_mag", bus.mag, 0);
    sqrt_lat = 5;
    run_vec(8'sd6, 8'sd8, 10, 100, "t5b");

    // 6: back-to-back random vectors with in_valid held high
    p0 = ready_pulses;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      xi = int'(x);
      yi = int'(y);
      es = xi * xi + yi * yi;
      sqrt_lat = int'($urandom_range(1, 9));
      bus.dx = x;
      bus.dy = y;
      wait_in_ready("t6");
      tick();
      wait_out("t6");
      check("t6_mag", bus.mag, isqrt(es));
      check("t6_sumsq", bus.sumsq, es);
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    check("t6_pulses", ready_pulses - p0, 20);
    check("sq_ready_single_cycle", double_ready, 0);
    check("sq_num_stable_window", num_changed, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
